// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a maskable interrupt.
// Optional prescaler on the count rate is enabled by defining TC_PRESCALE_EN.
module timer_counter #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
`ifdef TC_PRESCALE_EN
    localparam int unsigned PW = 16;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ctrl_q, ctrl_d;
    logic [DW-1:0]   preset_q, preset_d;
    logic [DW-1:0]   count_q, count_d;
    logic            flag_q, flag_d;
    logic            step;

`ifdef TC_PRESCALE_EN
    logic [PW-1:0]   presc_q, presc_d;
    assign step = (presc_q == PW'(PRESCALE - 1));
`else
    assign step = 1'b1;
`endif

    // Address bits outside [3:2] are decoded by the bridge, not here.
    logic unused_ok;
    assign unused_ok = &{1'b0, addr[31:4], addr[1:0], 32'(PRESCALE)};

    // State register and all architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
`ifdef TC_PRESCALE_EN
            presc_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
`ifdef TC_PRESCALE_EN
            presc_q  <= presc_d;
`endif
        end
    end

    // Next-state logic; the CPU write is applied last so it overrides the FSM.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
`ifdef TC_PRESCALE_EN
        presc_d  = presc_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
`ifdef TC_PRESCALE_EN
                presc_d = '0;
`endif
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else begin
`ifdef TC_PRESCALE_EN
                    presc_d = step ? '0 : presc_q + PW'(1);
`endif
                    if (step) begin
                        if (count_q > DW'(1)) begin
                            count_d = count_q - DW'(1);
                        end else begin
                            count_d = '0;
                            flag_d  = 1'b1;
                            state_d = S_INT;
                        end
                    end
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (ctrl_q[2:1] == 2'b01) begin
                    flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (we) begin
            case (addr[3:2])
                2'd0: begin
                    ctrl_d = din[CW-1:0];
                    flag_d = 1'b0;
                end
                2'd1: begin
                    preset_d = din;
                    flag_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read mux; no side effects.
    always_comb begin
        dout = '0;
        case (addr[3:2])
            2'd0:    dout = {(DW-CW)'(0), ctrl_q};
            2'd1:    dout = preset_q;
            2'd2:    dout = count_q;
            default: dout = '0;
        endcase
    end

    assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with a queue-based scoreboard of expected reads and irq levels.
module tb_timer_counter;

`ifdef TC_PRESCALE_EN
    localparam int unsigned PS = 4;
`else
    localparam int unsigned PS = 1;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    timer_counter #(.PRESCALE(PS)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t x;
        x = sb.pop_front();
        total++;
        assert (obs === x.exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
        end
    endtask

    // One clock edge passes; we stay in the negedge phase.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic chk_rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        addr = a;
        push(tag, e);
        #1;
        pop_cmp(dout);
    endtask

    task automatic chk_irq(input logic e, input string tag);
        push(tag, {31'b0, e});
        pop_cmp({31'b0, irq});
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        tick(2);
        reset = 1'b0;

        // Reset state
        chk_rd(32'h0, 32'h0, "rst_ctrl");
        chk_rd(32'h4, 32'h0, "rst_preset");
        chk_rd(32'h8, 32'h0, "rst_count");
        chk_rd(32'hC, 32'h0, "rst_rsvd");
        chk_irq(1'b0, "rst_irq");

        // Ignored writes and CTRL width
        wr(32'h8, 32'h1234);
        wr(32'hC, 32'h5678);
        chk_rd(32'h8, 32'h0, "wr_count_ignored");
        chk_rd(32'hC, 32'h0, "rsvd_read");
        wr(32'h0, 32'hFFFF_FFF6);
        chk_rd(32'h0, 32'h6, "ctrl_width");
        wr(32'h0, 32'h0);

        // Prescaled (or plain) latency: irq after edge 2+N*PS
        wr(32'h4, 32'd3);
        wr(32'h0, 32'h9);
        tick(2 + 3 * PS - 1);
        chk_irq(1'b0, "ps_before");
        tick(1);
        chk_irq(1'b1, "ps_at");
        wr(32'h0, 32'h0);
        chk_irq(1'b0, "ps_clear");
        tick(3);

`ifndef TC_PRESCALE_EN
        // Mode 0 one-shot, N=5
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);
        tick(6);
        chk_irq(1'b0, "m0_e6_irq");
        chk_rd(32'h8, 32'd1, "m0_e6_count");
        tick(1);
        chk_irq(1'b1, "m0_e7_irq");
        chk_rd(32'h8, 32'd0, "m0_e7_count");
        tick(1);
        chk_rd(32'h0, 32'h8, "m0_ctrl_selfclr");
        chk_irq(1'b1, "m0_e8_irq");
        tick(3);
        chk_irq(1'b1, "m0_hold_irq");
        wr(32'h0, 32'h0);
        chk_irq(1'b0, "m0_clear_irq");

        // Mode 1 auto-reload, N=3: period 6, COUNT 3,2,1,0,0,0
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        for (int e = 1; e <= 17; e++) begin
            int r;
            logic [31:0] ec;
            tick(1);
            r  = (e - 2) % 6;
            ec = (e < 2) ? 32'd0 : (r == 0) ? 32'd3 : (r == 1) ? 32'd2 : (r == 2) ? 32'd1 : 32'd0;
            chk_irq((e >= 2) && (r == 3), $sformatf("m1_irq_e%0d", e));
            chk_rd(32'h8, ec, $sformatf("m1_count_e%0d", e));
        end
        wr(32'h0, 32'h0);
        chk_irq(1'b0, "m1_stop_irq");
        tick(3);

        // Masked one-shot, N=4
        wr(32'h4, 32'd4);
        wr(32'h0, 32'h1);
        tick(6);
        chk_irq(1'b0, "mask_e6_irq");
        tick(1);
        chk_rd(32'h0, 32'h0, "mask_ctrl");
        chk_rd(32'h8, 32'h0, "mask_count");
        wr(32'h0, 32'h8);
        chk_irq(1'b0, "mask_unmask_irq");
        chk_rd(32'h0, 32'h8, "mask_ctrl8");
        wr(32'h0, 32'h0);

        // Freeze mid-count, then reload
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h9);
        tick(5);
        chk_rd(32'h8, 32'd7, "frz_e5_count");
        wr(32'h0, 32'h8);
        chk_rd(32'h8, 32'd6, "frz_e6_count");
        tick(3);
        chk_rd(32'h8, 32'd6, "frz_hold_count");
        chk_rd(32'h0, 32'h8, "frz_ctrl");
        wr(32'h4, 32'd2);
        chk_rd(32'h8, 32'd6, "frz_preset_nochange");
        wr(32'h0, 32'h9);
        tick(2);
        chk_rd(32'h8, 32'd2, "rl_count");
        tick(1);
        chk_irq(1'b0, "rl_e3_irq");
        tick(1);
        chk_irq(1'b1, "rl_e4_irq");
        wr(32'h0, 32'h0);
        chk_rd(32'h0, 32'h0, "rl_cpu_wins");
        chk_irq(1'b0, "rl_clear_irq");
        tick(2);

        // Reset mid-count
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h9);
        tick(6);
        chk_rd(32'h8, 32'd6, "mrst_pre_count");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_rd(32'h0, 32'h0, "mrst_ctrl");
        chk_rd(32'h4, 32'h0, "mrst_preset");
        chk_rd(32'h8, 32'h0, "mrst_count");
        chk_irq(1'b0, "mrst_irq");
        tick(4);
        chk_rd(32'h8, 32'h0, "mrst_idle_count");

        // CPU CTRL write beats the INT-state Enable clear
        wr(32'h4, 32'd1);
        wr(32'h0, 32'h9);
        tick(3);
        chk_irq(1'b1, "sim_irq");
        wr(32'h0, 32'h9);
        chk_rd(32'h0, 32'h9, "sim_ctrl_wins");
        chk_irq(1'b0, "sim_irq_cleared");
        tick(2);
        chk_irq(1'b0, "sim_restart_e2");
        tick(1);
        chk_irq(1'b1, "sim_restart_e3");
        wr(32'h4, 32'd5);
        chk_irq(1'b0, "sim_preset_clr");
        chk_rd(32'h0, 32'h8, "sim_ctrl_oneshot");

        // Write in the same edge the FSM would set irq_flag
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h9);
        tick(3);
        chk_rd(32'h8, 32'd1, "race_e3_count");
        wr(32'h4, 32'd2);
        chk_irq(1'b0, "race_e4_irq");
        tick(1);
        chk_irq(1'b0, "race_e5_irq");
        chk_rd(32'h0, 32'h8, "race_ctrl");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
